// File: rtl/mul_seq_pkg.sv
// Shared types and defaults for the iterative multiplier.
// The state encoding is fixed so the divider can reuse it.
package mul_seq_pkg;

  localparam int MUL_WIDTH = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/mul_cneg.sv
// Conditional two's-complement negator.
// Shared by the multiplier and the divider.
module mul_cneg #(
  parameter int W = 32
) (
  input  logic [W-1:0] in,
  input  logic         neg,
  output logic [W-1:0] out
);

  assign out = neg ? (~in + W'(1)) : in;

endmodule

// File: rtl/mul_seq.sv
// Iterative shift-add multiplier.
// WIDTH steps plus one sign fix-up cycle.
module mul_seq
  import mul_seq_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  state_t             state;
  state_t             nxt;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   ma;
  logic [WIDTH-1:0]   hi;
  logic [WIDTH-1:0]   lo;
  logic               neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] res;
  logic               accept;
  logic               last;

  mul_cneg #(.W(WIDTH)) u_amag (
    .in  (a),
    .neg (is_signed & a[WIDTH-1]),
    .out (a_mag)
  );

  mul_cneg #(.W(WIDTH)) u_bmag (
    .in  (b),
    .neg (is_signed & b[WIDTH-1]),
    .out (b_mag)
  );

  mul_cneg #(.W(2*WIDTH)) u_fix (
    .in  ({hi, lo}),
    .neg (neg),
    .out (res)
  );

  // One extra bit keeps the carry of each partial add.
  assign sum = {1'b0, hi} + (lo[0] ? {1'b0, ma} : '0);
  assign accept = in_valid & in_ready;
  assign last = (cnt == CNT_W'(WIDTH - 1));

  always_comb begin
    nxt       = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) nxt = S_BUSY;
      end
      S_BUSY: begin
        busy = 1'b1;
        if (last) nxt = S_FIX;
      end
      S_FIX: begin
        busy = 1'b1;
        nxt  = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) nxt = S_IDLE;
      end
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      ma      <= '0;
      hi      <= '0;
      lo      <= '0;
      neg     <= 1'b0;
      product <= '0;
    end else begin
      state <= nxt;
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            ma  <= a_mag;
            lo  <= b_mag;
            hi  <= '0;
            cnt <= '0;
            neg <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
          end
        end
        S_BUSY: begin
          hi  <= sum[WIDTH:1];
          lo  <= {sum[0], lo[WIDTH-1:1]};
          cnt <= cnt + CNT_W'(1);
        end
        S_FIX: product <= res;
        default: ;
      endcase
    end
  end

endmodule
